// File: rtl/ifu_pkg.sv
// Shared types for the instruction-fetch queue: the stored packet layout and lane constants.
// The packet geometry here must match the LANES/ADDR_W parameters of the queue that stores it.
package ifu_pkg;

    localparam int PKT_LANES  = 2;
    localparam int PKT_ADDR_W = 32;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [PKT_LANES*32-1:0] inst;
        logic [PKT_ADDR_W-1:0]   addr;
        logic [PKT_LANES-1:0]    mask;
        logic [PKT_LANES-1:0]    pred;
        logic                    err;
    } fetch_pkt_t;

endpackage

// File: rtl/ifu_lane_trunc.sv
// Clears every lane above the first valid predicted-taken lane; pred is then restricted to surviving lanes.
// Purely combinational, shared with the branch predictor.
module ifu_lane_trunc #(
    parameter int LANES = 2
) (
    input  logic [LANES-1:0] mask_i,
    input  logic [LANES-1:0] pred_i,
    output logic [LANES-1:0] mask_o,
    output logic [LANES-1:0] pred_o
);

    logic taken_seen;

    always_comb begin
        mask_o     = '0;
        taken_seen = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            // The taken lane itself survives; only later lanes are cut.
            mask_o[i]  = mask_i[i] & ~taken_seen;
            taken_seen = taken_seen | (mask_i[i] & pred_i[i]);
        end
        pred_o = pred_i & mask_o;
    end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch-packet queue between the fetch AXI master and decode: epoch-tagged flush, request
// reservations (credits), and lane truncation after predicted-taken branches.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int LANES   = PKT_LANES,
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = PKT_ADDR_W,
    parameter int EPOCH_W = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    output logic [EPOCH_W-1:0]        epoch_o,
    input  logic                      req_i,
    output logic [$clog2(DEPTH+1)-1:0] credit_o,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [LANES*32-1:0]       in_data_i,
    input  logic [ADDR_W-1:0]         in_addr_i,
    input  logic [LANES-1:0]          in_mask_i,
    input  logic [LANES-1:0]          in_pred_i,
    input  logic                      in_err_i,
    input  logic [EPOCH_W-1:0]        in_epoch_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [LANES*32-1:0]       out_inst_o,
    output logic [LANES*ADDR_W-1:0]   out_addr_o,
    output logic [LANES-1:0]          out_lane_valid_o,
    output logic [LANES-1:0]          out_pred_o,
    output logic                      out_err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    // Valid/ready: a beat transfers on a clock edge where valid and ready are both high;
    // valid never depends on ready, and in_ready_o/credit_o depend on registers and the epoch tag only.

    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      rsv_q, rsv_d;
    logic [PW-1:0]      wr_q, wr_d;
    logic [PW-1:0]      rd_q, rd_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    fetch_pkt_t         mem_q [DEPTH];

    logic [LANES-1:0] trunc_mask, trunc_pred;
    logic             stale, accept, push, pop, req_ok;
    fetch_pkt_t       head;

    ifu_lane_trunc #(.LANES(LANES)) u_trunc (
        .mask_i (in_mask_i),
        .pred_i (in_pred_i),
        .mask_o (trunc_mask),
        .pred_o (trunc_pred)
    );

    assign stale       = (in_epoch_i != epoch_q);
    assign in_ready_o  = stale | (count_q < CW'(DEPTH));
    assign credit_o    = CW'(DEPTH) - count_q - rsv_q;
    assign epoch_o     = epoch_q;
    assign out_valid_o = (count_q != '0);

    assign accept = in_valid_i & in_ready_o;
    // Empty, error-free packets carry nothing for decode and are not stored.
    assign push   = accept & ~stale & ~flush_i & ((|trunc_mask) | in_err_i);
    assign pop    = out_valid_o & out_ready_i & ~flush_i;
    // A flush frees every stored slot, so only outstanding reservations can block a new request.
    assign req_ok = req_i & (flush_i ? (rsv_q < CW'(DEPTH)) : (credit_o != '0));

    always_comb begin
        count_d = count_q;
        rsv_d   = rsv_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        epoch_d = epoch_q;
        if (req_ok) begin
            rsv_d = rsv_d + CW'(1);
        end
        if (accept && rsv_q != '0) begin
            rsv_d = rsv_d - CW'(1);
        end
        if (flush_i) begin
            count_d = '0;
            wr_d    = '0;
            rd_d    = '0;
            epoch_d = epoch_q + EPOCH_W'(1);
        end else begin
            if (push) begin
                wr_d = wr_q + PW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            rsv_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            epoch_q <= '0;
        end else begin
            count_q <= count_d;
            rsv_q   <= rsv_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            epoch_q <= epoch_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= '{inst: in_data_i, addr: in_addr_i, mask: trunc_mask,
                             pred: trunc_pred, err: in_err_i};
        end
    end

    assign head = mem_q[rd_q];

    always_comb begin
        out_inst_o       = '0;
        out_addr_o       = '0;
        out_lane_valid_o = '0;
        out_pred_o       = '0;
        out_err_o        = 1'b0;
        if (out_valid_o) begin
            out_inst_o       = head.inst;
            out_lane_valid_o = head.mask;
            out_pred_o       = head.pred;
            out_err_o        = head.err;
            for (int i = 0; i < LANES; i++) begin
                out_addr_o[i*ADDR_W +: ADDR_W] = head.addr + ADDR_W'(INST_BYTES * i);
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue (LANES=2, DEPTH=4): credits, truncation, flush/epoch, wrap-around.
module tb_ifu_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic [1:0]  epoch_o;
    logic        req_i;
    logic [2:0]  credit_o;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] in_data_i;
    logic [31:0] in_addr_i;
    logic [1:0]  in_mask_i;
    logic [1:0]  in_pred_i;
    logic        in_err_i;
    logic [1:0]  in_epoch_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_inst_o;
    logic [63:0] out_addr_o;
    logic [1:0]  out_lane_valid_o;
    logic [1:0]  out_pred_o;
    logic        out_err_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    ifu_fetch_queue #(.LANES(2), .DEPTH(4), .ADDR_W(32), .EPOCH_W(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_i          (flush_i),
        .epoch_o          (epoch_o),
        .req_i            (req_i),
        .credit_o         (credit_o),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_data_i        (in_data_i),
        .in_addr_i        (in_addr_i),
        .in_mask_i        (in_mask_i),
        .in_pred_i        (in_pred_i),
        .in_err_i         (in_err_i),
        .in_epoch_i       (in_epoch_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_inst_o       (out_inst_o),
        .out_addr_o       (out_addr_o),
        .out_lane_valid_o (out_lane_valid_o),
        .out_pred_o       (out_pred_o),
        .out_err_o        (out_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked in that same window.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i = 0; req_i = 0; in_valid_i = 0; in_data_i = '0; in_addr_i = '0;
        in_mask_i = '0; in_pred_i = '0; in_err_i = 0; in_epoch_i = '0; out_ready_i = 0;
    endtask

    task automatic drive_rsp(input logic [63:0] data, input logic [31:0] addr, input logic [1:0] mask,
                             input logic [1:0] pred, input logic err, input logic [1:0] ep);
        in_valid_i = 1; in_data_i = data; in_addr_i = addr; in_mask_i = mask;
        in_pred_i = pred; in_err_i = err; in_epoch_i = ep;
    endtask

    task automatic request(input int n);
        req_i = 1;
        repeat (n) step();
        req_i = 0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        out_ready_i = 1;
        while (out_valid_o && guard < 16) begin
            step();
            guard++;
        end
        out_ready_i = 0;
        check("drain_empty", 64'(out_valid_o), 64'd0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        step(); step();
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_credit", 64'(credit_o), 64'd4);
        check("rst_ready", 64'(in_ready_o), 64'd1);
        check("rst_epoch", 64'(epoch_o), 64'd0);
        check("rst_inst", out_inst_o, 64'd0);
        check("rst_addr", out_addr_o, 64'd0);
        rst_n = 1;
        step();

        // Reserve four slots, credit counts down 4->0
        req_i = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("credit_down", 64'(credit_o), 64'(3 - i));
        end
        // credit is 0: this request must be ignored
        step();
        req_i = 0;
        check("credit_sat", 64'(credit_o), 64'd0);

        for (int i = 0; i < 4; i++) begin
            drive_rsp({32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)}, 32'h200 + 32'(8 * i), 2'b11, 2'b00, 0, 2'd0);
            if (i == 0) check("no_bypass", 64'(out_valid_o), 64'd0);
            check("ready_fill", 64'(in_ready_o), 64'd1);
            step();
            if (i == 0) begin
                check("valid_1cyc", 64'(out_valid_o), 64'd1);
                check("head_inst", out_inst_o, 64'hB000_0000_A000_0000);
                check("head_addr", out_addr_o, 64'h0000_0204_0000_0200);
            end
        end
        check("full_ready", 64'(in_ready_o), 64'd0);
        check("full_credit", 64'(credit_o), 64'd0);
        // Push refused while full, pop proceeds
        out_ready_i = 1;
        step();
        in_valid_i = 0;
        out_ready_i = 0;
        check("full_pop_addr", 64'(out_addr_o[31:0]), 64'h208);
        check("full_pop_credit", 64'(credit_o), 64'd1);
        drain();
        check("drained_credit", 64'(credit_o), 64'd4);

        // Predicted-taken lane 0 truncates lane 1
        request(1);
        drive_rsp(64'h2222_2222_1111_1111, 32'h100, 2'b11, 2'b01, 0, 2'd0);
        step();
        in_valid_i = 0;
        check("trunc_mask", 64'(out_lane_valid_o), 64'b01);
        check("trunc_pred", 64'(out_pred_o), 64'b01);
        check("lane1_addr", 64'(out_addr_o[63:32]), 64'h104);
        drain();

        // Misaligned start, then an empty drop, then an error packet with empty mask
        request(3);
        drive_rsp(64'h4444_4444_3333_3333, 32'h108, 2'b10, 2'b00, 0, 2'd0);
        step();
        check("misal_mask", 64'(out_lane_valid_o), 64'b10);
        check("misal_inst1", 64'(out_inst_o[63:32]), 64'h4444_4444);
        check("misal_err", 64'(out_err_o), 64'd0);
        out_ready_i = 1;
        drive_rsp(64'h5, 32'h110, 2'b00, 2'b00, 0, 2'd0);
        step();
        check("empty_drop", 64'(out_valid_o), 64'd0);
        check("empty_credit", 64'(credit_o), 64'd3);
        out_ready_i = 0;
        drive_rsp(64'h6, 32'h118, 2'b00, 2'b00, 1, 2'd0);
        step();
        in_valid_i = 0;
        check("err_stored", 64'(out_valid_o), 64'd1);
        check("err_flag", 64'(out_err_o), 64'd1);
        check("err_mask", 64'(out_lane_valid_o), 64'd0);
        drain();
        check("err_credit", 64'(credit_o), 64'd4);

        // Two outstanding requests, flush, stale responses are swallowed
        request(2);
        flush_i = 1;
        step();
        flush_i = 0;
        check("flush_epoch", 64'(epoch_o), 64'd1);
        check("flush_credit", 64'(credit_o), 64'd2);
        for (int i = 0; i < 2; i++) begin
            drive_rsp(64'h7, 32'h300 + 32'(8 * i), 2'b11, 2'b00, 0, 2'd0);
            check("stale_ready", 64'(in_ready_o), 64'd1);
            step();
            check("stale_dropped", 64'(out_valid_o), 64'd0);
        end
        in_valid_i = 0;
        check("stale_credit", 64'(credit_o), 64'd4);

        // Full queue: flush + push + pop + req in one cycle
        request(4);
        for (int i = 0; i < 4; i++) begin
            drive_rsp(64'h8, 32'h400 + 32'(8 * i), 2'b11, 2'b00, 0, 2'd1);
            step();
        end
        check("refull_ready", 64'(in_ready_o), 64'd0);
        flush_i = 1; req_i = 1; out_ready_i = 1;
        step();
        idle_inputs();
        check("fflush_valid", 64'(out_valid_o), 64'd0);
        check("fflush_epoch", 64'(epoch_o), 64'd2);
        check("fflush_credit", 64'(credit_o), 64'd3);
        check("fflush_out", out_inst_o, 64'd0);
        drive_rsp(64'h9, 32'h500, 2'b11, 2'b00, 0, 2'd1);
        step();
        in_valid_i = 0;
        check("late_stale", 64'(credit_o), 64'd4);

        // Flush while a current-epoch push is accepted: packet dropped, reservation released
        request(1);
        drive_rsp(64'hA, 32'h600, 2'b11, 2'b00, 0, 2'd2);
        flush_i = 1;
        step();
        idle_inputs();
        check("fpush_valid", 64'(out_valid_o), 64'd0);
        check("fpush_epoch", 64'(epoch_o), 64'd3);
        check("fpush_credit", 64'(credit_o), 64'd4);

        // Wrap-around streaming, 12 packets, one push and one pop per cycle
        req_i = 1;
        step();
        out_ready_i = 1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                check("stream_valid", 64'(out_valid_o), 64'd1);
                if (exp_q.size() != 0) check("stream_addr", 64'(out_addr_o[31:0]), 64'(exp_q.pop_front()));
            end
            req_i = (k < 11);
            drive_rsp({32'hC000_0000 + 32'(k), 32'hD000_0000 + 32'(k)}, 32'h1000 + 32'(8 * k), 2'b11, 2'b00, 0, 2'd3);
            exp_q.push_back(32'h1000 + 32'(8 * k));
            step();
        end
        in_valid_i = 0; req_i = 0;
        check("stream_last_valid", 64'(out_valid_o), 64'd1);
        check("stream_last_addr", 64'(out_addr_o[31:0]), 64'(exp_q.pop_front()));
        check("stream_last_inst", out_inst_o, 64'hC000_000B_D000_000B);
        step();
        check("stream_end", 64'(out_valid_o), 64'd0);
        check("stream_credit", 64'(credit_o), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
